// File: rtl/pulp_sync_event_sched.sv
// -----------------------------------------------------------------------------
// pulp_sync_event_sched
//   Multi-channel edge-event scheduler. Each channel synchronizes an
//   asynchronous input, optionally debounces it, detects enabled rising /
//   falling edges and latches them as pending events. A round-robin arbiter
//   drains pending events one at a time over a valid/ready interface.
//
//   Build option: define PULP_SYNC_SCHED_DEBOUNCE_EN to build the debounce
//   counters; otherwise db_cycles_i is ignored and timing equals D = 0.
//
// Ports
//   clk, rstn_i   clock, async active-low reset
//   en_i          per-channel enable
//   serial_i      asynchronous inputs
//   rise_en_i     event on rising edge, per channel
//   fall_en_i     event on falling edge, per channel
//   db_cycles_i   debounce length D (quasi-static)
//   clr_ovf_i     clear sticky overflow, per channel
//   evt_valid_o   event offered
//   evt_ready_i   consumer accepts
//   evt_ch_o      channel index of the offered event
//   evt_rise_o    1 = rising, 0 = falling
//   level_o       debounced level per channel
//   overflow_o    sticky lost-event flag per channel
// -----------------------------------------------------------------------------

// Per-channel front end: synchronizer, debounce, edge detect.
// o_edge is combinational and coincides with the clock edge that updates
// o_level, so pending bits update at the same edge as the level.
module pulp_sync_event_sched_ch #(
    parameter int STAGES = 2,
    parameter int DB_W   = 8
) (
    input  logic            clk,
    input  logic            rstn_i,
    input  logic            i_en,
    input  logic            i_serial,
    input  logic [DB_W-1:0] i_db_cycles,
    output logic            o_level,
    output logic            o_edge,
    output logic            o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_level;
    logic              w_sync;

    assign w_sync = r_sync[STAGES-1];

    // Synchronizer runs regardless of enable.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_sync <= '0;
        else         r_sync <= {r_sync[STAGES-2:0], i_serial};
    end

`ifdef PULP_SYNC_SCHED_DEBOUNCE_EN
    logic [DB_W-1:0] r_cnt;

    assign o_edge = i_en && (w_sync != r_level) && (r_cnt == i_db_cycles);

    // Count consecutive cycles of disagreement; any agreement restarts it.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if ((w_sync == r_level) || (r_cnt == i_db_cycles)) r_cnt <= '0;
            else                                               r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_db_unused;
    assign w_db_unused = ^i_db_cycles;
    assign o_edge      = i_en && (w_sync != r_level);
`endif

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i)     r_level <= 1'b0;
        else if (o_edge) r_level <= w_sync;
    end

    assign o_level = r_level;
    assign o_rise  = w_sync;
endmodule

module pulp_sync_event_sched #(
    parameter int N_CH   = 4,
    parameter int STAGES = 2,
    parameter int DB_W   = 8
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic [N_CH-1:0]         en_i,
    input  logic [N_CH-1:0]         serial_i,
    input  logic [N_CH-1:0]         rise_en_i,
    input  logic [N_CH-1:0]         fall_en_i,
    input  logic [DB_W-1:0]         db_cycles_i,
    input  logic [N_CH-1:0]         clr_ovf_i,
    output logic                    evt_valid_o,
    input  logic                    evt_ready_i,
    output logic [$clog2(N_CH)-1:0] evt_ch_o,
    output logic                    evt_rise_o,
    output logic [N_CH-1:0]         level_o,
    output logic [N_CH-1:0]         overflow_o
);
    localparam int CW = $clog2(N_CH);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    state_t          r_state, w_state_nxt;
    logic [N_CH-1:0] w_edge, w_rise, w_new, w_ld;
    logic [N_CH-1:0] r_pend, r_ptype, r_ovf;
    logic [CW-1:0]   r_ptr, r_ch, w_grant, w_idx;
    logic [CW:0]     w_sum;
    logic            r_rise, w_found, w_load;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pulp_sync_event_sched_ch #(.STAGES(STAGES), .DB_W(DB_W)) u_ch (
            .clk         (clk),
            .rstn_i      (rstn_i),
            .i_en        (en_i[c]),
            .i_serial    (serial_i[c]),
            .i_db_cycles (db_cycles_i),
            .o_level     (level_o[c]),
            .o_edge      (w_edge[c]),
            .o_rise      (w_rise[c])
        );
    end

    assign w_new = w_edge & ((w_rise & rise_en_i) | (~w_rise & fall_en_i));

    // First pending channel at or after r_ptr, cyclically.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sum = {1'b0, r_ptr} + (CW+1)'(i);
            if (w_sum >= (CW+1)'(N_CH)) w_sum = w_sum - (CW+1)'(N_CH);
            w_idx = w_sum[CW-1:0];
            if (!w_found && r_pend[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready_i) begin
                    w_load      = w_found;
                    w_state_nxt = w_found ? S_OFFER : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_ld = w_load ? (N_CH'(1) << w_grant) : '0;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_ch    <= '0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_ch   <= w_grant;
                r_rise <= r_ptype[w_grant];
                r_ptr  <= (w_grant == CW'(N_CH-1)) ? '0 : w_grant + 1'b1;
            end
        end
    end

    // A new edge on the channel being loaded re-arms pend without overflow;
    // otherwise a second edge on a pending channel is dropped and flagged.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pend  <= '0;
            r_ptype <= '0;
            r_ovf   <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (w_new[c] && (!r_pend[c] || w_ld[c])) begin
                    r_pend[c]  <= 1'b1;
                    r_ptype[c] <= w_rise[c];
                end else if (w_ld[c]) begin
                    r_pend[c]  <= 1'b0;
                end
                if (w_new[c] && r_pend[c] && !w_ld[c]) r_ovf[c] <= 1'b1;
                else if (clr_ovf_i[c])                 r_ovf[c] <= 1'b0;
            end
        end
    end

    assign evt_valid_o = (r_state == S_OFFER);
    assign evt_ch_o    = r_ch;
    assign evt_rise_o  = r_rise;
    assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_pulp_sync_event_sched.sv
// -----------------------------------------------------------------------------
// tb_pulp_sync_event_sched
//   Directed bench with a scoreboard: stimulus pushes expected events into a
//   queue, a monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_pulp_sync_event_sched;
    localparam int N_CH = 4;
    localparam int DB_W = 8;

    typedef struct packed {
        logic [1:0] ch;
        logic       rise;
    } ev_t;

    logic            clk = 1'b0;
    logic            rstn_i;
    logic [N_CH-1:0] en_i, serial_i, rise_en_i, fall_en_i, clr_ovf_i;
    logic [DB_W-1:0] db_cycles_i;
    logic            evt_valid_o, evt_ready_i, evt_rise_o;
    logic [1:0]      evt_ch_o;
    logic [N_CH-1:0] level_o, overflow_o;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];

    pulp_sync_event_sched #(.N_CH(N_CH), .STAGES(2), .DB_W(DB_W)) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .en_i        (en_i),
        .serial_i    (serial_i),
        .rise_en_i   (rise_en_i),
        .fall_en_i   (fall_en_i),
        .db_cycles_i (db_cycles_i),
        .clr_ovf_i   (clr_ovf_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ch_o    (evt_ch_o),
        .evt_rise_o  (evt_rise_o),
        .level_o     (level_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic rise);
        ev_t e;
        e.ch   = ch;
        e.rise = rise;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn_i && evt_valid_o && evt_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: got ch=%0d rise=%0d expected none",
                         evt_ch_o, evt_rise_o);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (evt_ch_o !== e.ch || evt_rise_o !== e.rise) begin
                    n_errors++;
                    $display("FAIL event: got ch=%0d rise=%0d expected ch=%0d rise=%0d",
                             evt_ch_o, evt_rise_o, e.ch, e.rise);
                end
            end
        end
    end

    initial begin
        int bad;
        rstn_i      = 1'b0;
        en_i        = '1;
        serial_i    = '0;
        rise_en_i   = '1;
        fall_en_i   = '0;
        clr_ovf_i   = '0;
        db_cycles_i = '0;
        evt_ready_i = 1'b1;
        tick(3);
        rstn_i = 1'b1;
        tick(2);

        // Reset state
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_ch",    32'(evt_ch_o),    32'd0);
        chk("rst_rise",  32'(evt_rise_o),  32'd0);
        chk("rst_level", 32'(level_o),     32'd0);
        chk("rst_ovf",   32'(overflow_o),  32'd0);

        // Latency: input sampled at edge k -> valid after edge k+3
        push(2'd1, 1'b1);
        serial_i[1] = 1'b1;
        tick(1);
        tick(2);
        chk("lat_valid_k2", 32'(evt_valid_o), 32'd0);
        tick(1);
        chk("lat_valid_k3", 32'(evt_valid_o), 32'd1);
        chk("lat_ch",       32'(evt_ch_o),    32'd1);
        chk("lat_rise",     32'(evt_rise_o),  32'd1);
        chk("lat_level",    32'(level_o),     32'b0010);
        tick(3);

`ifdef PULP_SYNC_SCHED_DEBOUNCE_EN
        // D=3: 3-cycle pulse filtered, 4-cycle pulse gives rise + fall
        db_cycles_i  = 8'd3;
        fall_en_i[0] = 1'b1;
        serial_i[0]  = 1'b1;
        tick(3);
        serial_i[0] = 1'b0;
        tick(10);
        chk("db_short_level", 32'(level_o[0]), 32'd0);
        push(2'd0, 1'b1);
        push(2'd0, 1'b0);
        serial_i[0] = 1'b1;
        tick(4);
        serial_i[0] = 1'b0;
        tick(3);
        chk("db_long_level_hi", 32'(level_o[0]), 32'd1);
        tick(12);
        chk("db_long_level_lo", 32'(level_o[0]), 32'd0);
        db_cycles_i = 8'd0;
`else
        // No debounce: db_cycles_i ignored, a 1-cycle pulse gives rise + fall
        db_cycles_i  = 8'd3;
        fall_en_i[0] = 1'b1;
        push(2'd0, 1'b1);
        push(2'd0, 1'b0);
        serial_i[0] = 1'b1;
        tick(1);
        serial_i[0] = 1'b0;
        tick(2);
        chk("nodb_level_hi", 32'(level_o[0]), 32'd1);
        tick(8);
        chk("nodb_level_lo", 32'(level_o[0]), 32'd0);
        db_cycles_i = 8'd0;
`endif
        fall_en_i = '0;

        // Fresh reset so ptr = 0 for the arbitration check
        serial_i = '0;
        tick(4);
        rstn_i = 1'b0;
        tick(2);
        rstn_i = 1'b1;
        tick(2);

        // Arbitration: channels 0,2,3 together -> 0,2,3 back to back
        push(2'd0, 1'b1);
        push(2'd2, 1'b1);
        push(2'd3, 1'b1);
        serial_i = 4'b1101;
        tick(3);
        chk("arb_k2_valid", 32'(evt_valid_o), 32'd0);
        tick(1);
        chk("arb_k3", 32'({evt_valid_o, evt_ch_o}), 32'b100);
        tick(1);
        chk("arb_k4", 32'({evt_valid_o, evt_ch_o}), 32'b110);
        tick(1);
        chk("arb_k5", 32'({evt_valid_o, evt_ch_o}), 32'b111);
        tick(1);
        chk("arb_k6_idle", 32'(evt_valid_o), 32'd0);
        // ptr wrapped to 0: channel 0 beats channel 1
        serial_i = '0;
        tick(5);
        push(2'd0, 1'b1);
        push(2'd1, 1'b1);
        serial_i = 4'b0011;
        tick(8);

        // Backpressure and overflow on channel 2
        evt_ready_i  = 1'b0;
        fall_en_i[2] = 1'b1;
        push(2'd2, 1'b1);
        push(2'd2, 1'b0);
        serial_i[2] = 1'b1;
        tick(4);
        chk("bp_offer", 32'({evt_valid_o, evt_ch_o, evt_rise_o}), 32'b1101);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(evt_valid_o && evt_ch_o == 2'd2 && evt_rise_o)) bad++;
        end
        chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
        serial_i[2] = 1'b0;
        tick(4);
        chk("bp_no_ovf_yet", 32'(overflow_o), 32'd0);
        serial_i[2] = 1'b1;
        tick(4);
        chk("bp_ovf_set", 32'(overflow_o), 32'b0100);
        clr_ovf_i[2] = 1'b1;
        tick(1);
        clr_ovf_i[2] = 1'b0;
        chk("bp_ovf_clr", 32'(overflow_o), 32'd0);
        evt_ready_i = 1'b1;
        tick(4);
        chk("bp_level", 32'(level_o[2]), 32'd1);

        // Enable gating: pending ch2 fall survives disabling ch2
        evt_ready_i = 1'b0;
        push(2'd3, 1'b1);
        push(2'd2, 1'b0);
        serial_i[3] = 1'b1;
        tick(5);
        chk("en_offer_ch3", 32'({evt_valid_o, evt_ch_o}), 32'b111);
        serial_i[2] = 1'b0;
        tick(4);
        en_i[2]     = 1'b0;
        serial_i[2] = 1'b1;
        tick(4);
        chk("en_level_hold_hi", 32'(level_o[2]), 32'd0);
        serial_i[2] = 1'b0;
        tick(3);
        serial_i[2] = 1'b1;
        tick(3);
        serial_i[2] = 1'b0;
        tick(4);
        chk("en_level_hold_lo", 32'(level_o[2]), 32'd0);
        evt_ready_i = 1'b1;
        tick(6);
        en_i[2] = 1'b1;
        tick(2);

        // Reset mid-operation with 3 events pending
        evt_ready_i = 1'b0;
        fall_en_i   = '0;
        serial_i    = '0;
        tick(4);
        serial_i = 4'b1111;
        tick(6);
        chk("mid_valid_before", 32'(evt_valid_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("mid_valid_async", 32'(evt_valid_o), 32'd0);
        serial_i = '0;
        tick(3);
        rstn_i      = 1'b1;
        evt_ready_i = 1'b1;
        tick(12);
        chk("mid_after_valid", 32'(evt_valid_o), 32'd0);
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pulp_sync_event_sched.md
# pulp_sync_event_sched

Multi-channel edge-event scheduler for asynchronous single-bit inputs such as GPIO pins, external interrupts and handshake lines. Each channel synchronizes its input, optionally debounces it and detects enabled rising and falling edges. Each detected edge is latched as a pending event. A round-robin arbiter drains pending events one at a time over a valid/ready interface to a single consumer, such as an interrupt controller or event unit.

## Interface
Parameters:
- `N_CH`, default 4: number of input channels (≥2).
- `STAGES`, default 2: synchronizer depth per channel (≥2).
- `DB_W`, default 8: debounce counter width.

Ports:
- `clk`  in  1  clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  N_CH  per-channel enable.
- `serial_i`  in  N_CH  asynchronous inputs.
- `rise_en_i`  in  N_CH  generate an event on a rising edge.
- `fall_en_i`  in  N_CH  generate an event on a falling edge.
- `db_cycles_i`  in  DB_W  debounce length D; quasi-static.
- `clr_ovf_i`  in  N_CH  clear the sticky overflow flags, one bit per channel.
- `evt_valid_o`  out  1  event offered.
- `evt_ready_i`  in  1  consumer accepts the event.
- `evt_ch_o`  out  $clog2(N_CH)  channel index of the offered event.
- `evt_rise_o`  out  1  1 = rising edge, 0 = falling edge.
- `level_o`  out  N_CH  debounced stable level per channel.
- `overflow_o`  out  N_CH  sticky: an event was lost.

## Operation
Reset values:
- All synchronizer flops, `level_o`, counters, pending bits and `overflow_o` are 0.
- `evt_valid_o`, `evt_ch_o` and `evt_rise_o` are 0.
- The round-robin pointer is 0.

Per channel, when `en_i[c]` = 1:
- `serial_i[c]` passes through `STAGES` flops to produce `sync[c]`.
- At each edge where `sync` ≠ `level`:
  - if `cnt` = D: `level` <= `sync`, `cnt` <= 0, and an edge is detected;
  - otherwise: `cnt` <= `cnt`+1.
- At each edge where `sync` = `level`: `cnt` <= 0. A glitch shorter than D+1 cycles is filtered.
- A detected edge that is enabled by `rise_en_i` / `fall_en_i` sets `pend[c]` and stores its type in `ptype[c]`. A disabled edge still updates `level`.
- Overflow: a new enabled edge arrives while `pend[c]` = 1 and the channel is not being loaded into the output this cycle.
  - `overflow_o[c]` <= 1.
  - The pending event keeps its original type; the new edge is dropped.
- When `en_i[c]` = 0:
  - the synchronizer keeps running;
  - `cnt` and `level` hold;
  - no new events are generated;
  - any existing `pend[c]` is kept and still arbitrated.
- `clr_ovf_i[c]` clears `overflow_o[c]`. If a clear and a new overflow occur in the same cycle, the set wins.

Arbiter FSM:
- IDLE:
  - if any `pend` is set, grant the first set bit at or after `ptr`, cyclically;
  - load `evt_ch_o` and `evt_rise_o` from that channel, clear its `pend` bit, set `ptr` <= grant+1 (wrapping N_CH-1 → 0);
  - go to OFFER.
- OFFER:
  - `evt_valid_o` = 1; `evt_ch_o` and `evt_rise_o` are held stable until a handshake;
  - on `evt_valid_o` & `evt_ready_i`: if another `pend` bit is set, load the next grant in the same cycle and stay in OFFER; otherwise go to IDLE.
- Simultaneous events:
  - a new enabled edge on channel c in the same cycle c is loaded into the output leaves `pend[c]` = 1 and is not an overflow;
  - several channels pending: served in strict rotation, so no channel waits more than N_CH handshakes.
- Reset mid-operation: everything returns to its reset value immediately (asynchronous); in-flight and pending events are discarded.

## Timing
- Input high first sampled at edge k:
  - `sync` high after edge k+STAGES-1;
  - `level_o` and `pend` update at edge k+STAGES+D;
  - `evt_valid_o` rises after edge k+STAGES+D+1.
- `evt_valid_o`, `evt_ch_o` and `evt_rise_o` are registered.
- `evt_ready_i` has no combinational path to any output.
- Throughput: one event per cycle while `evt_ready_i` is held high.
- `ptr` advances only on a load. It does not advance while valid is stalled.

## Configuration
- `PULP_SYNC_SCHED_DEBOUNCE_EN` defined: the debounce counters are built as described above.
- Not defined:
  - no counters are instantiated and `db_cycles_i` is ignored;
  - `level` <= `sync` every enabled cycle;
  - timing is identical to D = 0.

## Test plan
- Reset check: with STAGES=2, D=0, `rise_en_i[1]`=1 and `serial_i[1]` 0→1 sampled at edge k, `evt_valid_o` = 1 after edge k+3 with `evt_ch_o`=1 and `evt_rise_o`=1. Before the input change, all outputs read 0 after reset.
- Debounce, D=3, macro defined: a 3-cycle high pulse gives no event and `level_o` stays 0. A 4-cycle pulse gives a rise event followed by a fall event when `fall_en_i`=1.
- Arbitration: channels 0, 2 and 3 rise in the same cycle with `evt_ready_i`=1. Grants come out 0, 2, 3 on consecutive cycles. A later channel-0 event after ptr=0 is granted next.
- Backpressure: with `evt_ready_i`=0 for 10 cycles, the outputs stay stable. A second edge on the same channel sets `overflow_o`. `clr_ovf_i` clears it one cycle later.
- Enable gating: with `en_i[2]`=0, toggling `serial_i[2]` produces no event and `level_o[2]` holds. A pending bit set earlier is still delivered.
- Reset mid-operation: assert `rstn_i` while in OFFER with 3 events pending. `evt_valid_o` drops asynchronously, and after release nothing is emitted.
